f_matrix_gen: RTL

- Parametrised successor to the fixed 12x12 constant-jerk state-transition generator.
- Builds the N_AXES*(ORDER+1)-square double-precision Kalman transition matrix F for a per-axis Taylor kinematic model: entries dt^k/k!.
- Uses one shared fp_multiplier and reciprocal-factorial constants, so no dividers are needed. Works under a start/done handshake with a repeat-dt fast path.
- Sits between the dt source and the predict stage (F*x, F*P*F').

---
 rtl/f_matrix_gen_if.sv | 19 +
 rtl/f_matrix_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/f_matrix_gen_if.sv
// ---------------------------------------------------------------------------
// f_matrix_gen_if
// Handshake bundle between the dt source and the F-matrix generator.
//   start   : one-cycle request, honoured only while the generator is idle
//   deltat  : IEEE-754 double time step, captured with an accepted start
//   busy    : generator is running the multiply sequence
//   done    : one-cycle pulse, coef/F have been refreshed
//   f_valid : F holds a complete result for the last accepted dt
// ---------------------------------------------------------------------------
interface f_matrix_gen_if;
    logic        start;
    logic [63:0] deltat;
    logic        busy;
    logic        done;
    logic        f_valid;

    modport master (output start, output deltat, input busy, input done, input f_valid);
    modport slave  (input start, input deltat, output busy, output done, output f_valid);
endinterface

// File: rtl/f_matrix_gen.sv
// ---------------------------------------------------------------------------
// f_matrix_gen
// Builds the DIM x DIM double-precision Kalman transition matrix for a
// per-axis Taylor kinematic model: F[i][j] = dt^(kj-ki)/(kj-ki)! on matching
// axes, zero elsewhere. The coefficients dt^k/k! are produced by one shared
// pipelined multiplier using reciprocal-factorial constants, so no divider.
// Ports:
//   clk   : clock
//   rst_n : synchronous, active-HIGH reset (legacy name)
//   bus   : start/deltat/busy/done/f_valid handshake (slave side)
//   coef  : coef[k] = dt^k/k!, coef[0] = 1.0
//   F     : transition matrix, combinational from coef
// ---------------------------------------------------------------------------

// IEEE-754 double multiplier, round-to-nearest-even, fixed latency LAT.
//   i_valid/i_a/i_b : operands, sampled in the valid cycle
//   o_finish        : high exactly LAT cycles after i_valid
//   o_result        : product, valid alongside o_finish
module fp_multiplier #(
    parameter int LAT = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    output logic        o_finish,
    output logic [63:0] o_result
);
    logic               r_vld_pipe [LAT:1];
    logic [63:0]        r_res_pipe [LAT:1];
    logic [63:0]        w_res;

    logic [10:0]        w_ea, w_eb;
    logic [52:0]        w_ma, w_mb;
    logic [105:0]       w_prod;
    logic [6:0]         w_msb;
    logic signed [13:0] w_e, w_sh;
    logic [6:0]         w_shc;
    logic [127:0]       w_pext, w_mask;
    logic [51:0]        w_frac;
    logic               w_guard, w_sticky, w_sign;
    logic [62:0]        w_pack;
    logic               w_nan, w_inf, w_zero;

    always_comb begin
        w_sign = i_a[63] ^ i_b[63];
        // Denormals use exponent 1 with no hidden bit.
        w_ea   = (i_a[62:52] == '0) ? 11'd1 : i_a[62:52];
        w_eb   = (i_b[62:52] == '0) ? 11'd1 : i_b[62:52];
        w_ma   = {(i_a[62:52] != '0), i_a[51:0]};
        w_mb   = {(i_b[62:52] != '0), i_b[51:0]};
        w_prod = {53'd0, w_ma} * {53'd0, w_mb};
        w_msb  = '0;
        for (int i = 0; i < 106; i++)
            if (w_prod[i]) w_msb = 7'(i);
        // Biased exponent once the leading one sits at bit 52.
        w_e    = 14'(w_ea) + 14'(w_eb) + 14'(w_msb) - 14'sd1127;
        // Right shift to normalise; extra shift when the result is subnormal.
        w_sh   = 14'(w_msb) - 14'sd52;
        if (w_e < 14'sd1) w_sh = w_sh + 14'sd1 - w_e;
        w_shc  = (w_sh > 14'sd120) ? 7'd120 : 7'(w_sh);
        w_pext = {22'd0, w_prod};
        w_frac = 52'(w_pext >> w_shc);
        w_mask = (128'd1 << (w_shc - 7'd1)) - 128'd1;
        w_guard  = (w_shc != '0) && w_pext[w_shc - 7'd1];
        w_sticky = (w_shc > 7'd1) && ((w_pext & w_mask) != '0);
        w_pack = (w_e < 14'sd1) ? {11'd0, w_frac} : {w_e[10:0], w_frac};
        // Carry out of the fraction rolls naturally into the exponent field.
        w_pack = w_pack + 63'(w_guard & (w_sticky | w_frac[0]));

        w_nan  = ((i_a[62:52] == 11'h7FF) && (i_a[51:0] != '0)) ||
                 ((i_b[62:52] == 11'h7FF) && (i_b[51:0] != '0));
        w_inf  = (i_a[62:52] == 11'h7FF) || (i_b[62:52] == 11'h7FF);
        w_zero = (i_a[62:0] == '0) || (i_b[62:0] == '0);

        if (w_nan || (w_inf && w_zero)) w_res = 64'h7FF8000000000000;
        else if (w_inf)                 w_res = {w_sign, 11'h7FF, 52'd0};
        else if (w_zero)                w_res = {w_sign, 63'd0};
        else if (w_e >= 14'sd2047)      w_res = {w_sign, 11'h7FF, 52'd0};
        else                            w_res = {w_sign, w_pack};
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int s = 1; s <= LAT; s++) r_vld_pipe[s] <= 1'b0;
        end else begin
            r_vld_pipe[1] <= i_valid;
            for (int s = 2; s <= LAT; s++) r_vld_pipe[s] <= r_vld_pipe[s-1];
        end
    end

    always_ff @(posedge clk) begin
        r_res_pipe[1] <= w_res;
        for (int s = 2; s <= LAT; s++) r_res_pipe[s] <= r_res_pipe[s-1];
    end

    assign o_finish = r_vld_pipe[LAT];
    assign o_result = r_res_pipe[LAT];
endmodule

module f_matrix_gen #(
    parameter int  N_AXES  = 3,
    parameter int  ORDER   = 3,
    parameter int  MUL_LAT = 6,
    localparam int DIM     = N_AXES * (ORDER + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    f_matrix_gen_if.slave bus,
    output logic [63:0]   coef [ORDER+1],
    output logic [63:0]   F    [DIM][DIM]
);
    localparam int          M    = 2 * (ORDER - 1);
    localparam logic [63:0] ONE  = 64'h3FF0000000000000;

    typedef enum logic [1:0] {IDLE, MUL_ISSUE, MUL_WAIT, FINISH} state_t;

    state_t      r_state, w_next;
    logic [63:0] r_dt, r_p, r_last_dt;
    logic [63:0] r_coef [ORDER+1];
    logic [3:0]  r_op;
    logic        r_dt_seen, r_fvalid;

    logic        w_accept, w_fast, w_last_op;
    logic        w_mul_vld, w_mul_fin;
    logic [63:0] w_mul_b, w_mul_res;
    logic [2:0]  w_k;

    function automatic logic [63:0] invf(input logic [2:0] k);
        case (k)
            3'd2:    invf = 64'h3FE0000000000000;  // 1/2
            3'd3:    invf = 64'h3FC5555555555555;  // 1/6
            3'd4:    invf = 64'h3FA5555555555555;  // 1/24
            3'd5:    invf = 64'h3F81111111111111;  // 1/120
            3'd6:    invf = 64'h3F56C16C16C16C17;  // 1/720
            default: invf = ONE;
        endcase
    endfunction

    // Op sequence: even op -> p = p*dt, odd op -> coef[k] = p/k!.
    assign w_k       = r_op[3:1] + 3'd2;
    assign w_mul_b   = r_op[0] ? invf(w_k) : r_dt;
    assign w_accept  = (r_state == IDLE) && bus.start;
    // ORDER==1 needs no multiplies at all: coef[1] is just dt.
    assign w_fast    = (r_dt_seen && (bus.deltat == r_last_dt)) || (ORDER == 1);
    assign w_last_op = (r_op == 4'(M - 1));

    fp_multiplier #(.LAT(MUL_LAT)) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (w_mul_vld),
        .i_a      (r_p),
        .i_b      (w_mul_b),
        .o_finish (w_mul_fin),
        .o_result (w_mul_res)
    );

    always_ff @(posedge clk) begin
        if (rst_n) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_mul_vld   = 1'b0;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.f_valid = r_fvalid;
        case (r_state)
            IDLE: if (bus.start) w_next = w_fast ? FINISH : MUL_ISSUE;
            MUL_ISSUE: begin
                w_mul_vld = 1'b1;
                bus.busy  = 1'b1;
                w_next    = MUL_WAIT;
            end
            MUL_WAIT: begin
                bus.busy = 1'b1;
                if (w_mul_fin) w_next = w_last_op ? FINISH : MUL_ISSUE;
            end
            FINISH: begin
                bus.done    = 1'b1;
                bus.f_valid = 1'b1;
                w_next      = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_dt      <= '0;
            r_p       <= '0;
            r_last_dt <= '0;
            r_op      <= '0;
            r_dt_seen <= 1'b0;
            r_fvalid  <= 1'b0;
            r_coef[0] <= ONE;
            for (int k = 1; k <= ORDER; k++) r_coef[k] <= '0;
        end else begin
            if (w_accept) begin
                r_dt     <= bus.deltat;
                r_p      <= bus.deltat;
                r_op     <= '0;
                r_fvalid <= 1'b0;
                if (!w_fast || (ORDER == 1)) r_coef[1] <= bus.deltat;
            end
            // Finish is only meaningful while waiting; strays are dropped.
            if ((r_state == MUL_WAIT) && w_mul_fin) begin
                r_op <= r_op + 4'd1;
                if (!r_op[0]) r_p <= w_mul_res;
                else
                    for (int k = 2; k <= ORDER; k++)
                        if (w_k == 3'(k)) r_coef[k] <= w_mul_res;
            end
            if (r_state == FINISH) begin
                r_last_dt <= r_dt;
                r_dt_seen <= 1'b1;
                r_fvalid  <= 1'b1;
            end
        end
    end

    assign coef = r_coef;

    // Upper-triangular block structure per axis: state index s = k*N_AXES + a.
    for (genvar gi = 0; gi < DIM; gi++) begin : g_row
        for (genvar gj = 0; gj < DIM; gj++) begin : g_col
            localparam int KI = gi / N_AXES;
            localparam int AI = gi % N_AXES;
            localparam int KJ = gj / N_AXES;
            localparam int AJ = gj % N_AXES;
            if ((AI == AJ) && (KJ >= KI)) begin : g_nz
                assign F[gi][gj] = r_coef[KJ-KI];
            end else begin : g_z
                assign F[gi][gj] = '0;
            end
        end
    end
endmodule
